// File: rtl/custom_logic_merge_pkg.sv
// custom_logic_merge_pkg: shared types and helpers for the 2:1 round-robin
// stream merge (custom_logic_merge) and its arbiter (rr_arbiter2).
package custom_logic_merge_pkg;

    // Source branch identity, used both for the output tag and the arbiter's
    // record of the most recent winner.
    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    // Last-grant value after reset: pretending B won last makes A win the
    // first contention.
    localparam src_t SRC_RESET = SRC_B;

    // Width of the one-hot grant vector (bit 0 = A, bit 1 = B).
    localparam int GRANT_W = 2;

    // Map a one-hot grant vector onto the branch it selects. An empty or
    // illegal vector maps to A; callers only use the result on a real transfer.
    function automatic src_t grant_to_src(input logic [GRANT_W-1:0] grant);
        src_t src;
        case (grant)
            2'b01:   src = SRC_A;
            2'b10:   src = SRC_B;
            default: src = SRC_A;
        endcase
        return src;
    endfunction

    // One-hot-or-zero check on a grant vector; lets any consumer confirm
    // that both branches are never granted together.
    function automatic logic grant_is_legal(input logic [GRANT_W-1:0] grant);
        return (grant != 2'b11);
    endfunction

endpackage

// File: rtl/custom_logic_merge_arb.sv
// rr_arbiter2: two-requester arbiter for custom_logic_merge.
// req[0] = branch A, req[1] = branch B; grant is one-hot or zero and purely
// combinational so the merge can drive up_ready in the same cycle.
// Default build: round-robin on contention, rotating only when 'advance'
// reports an actual transfer.
// CUSTOM_LOGIC_MERGE_PRIORITY_A_EN defined: fixed priority to A; no
// rotation state exists in that build.
module rr_arbiter2
    import custom_logic_merge_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [GRANT_W-1:0] req,
    input  logic               advance,
    output logic [GRANT_W-1:0] grant
);

    logic [GRANT_W-1:0] grant_s;

`ifdef CUSTOM_LOGIC_MERGE_PRIORITY_A_EN

    // Rotation state is not needed; fold the otherwise idle inputs away.
    logic unused_s;
    assign unused_s = ^{clk, rst, advance};

    // Fixed priority: A whenever it requests, otherwise B if it requests.
    always_comb begin
        grant_s = 2'b00;
        if (req[0]) begin
            grant_s = 2'b01;
        end else if (req[1]) begin
            grant_s = 2'b10;
        end else begin
            grant_s = 2'b00;
        end
    end

`else

    src_t last_grant_r;

    // Round-robin grant: a lone requester always wins; on contention the
    // branch that did not win last time is chosen.
    always_comb begin
        grant_s = 2'b00;
        case (req)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = (last_grant_r == SRC_B) ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
    end

    // Remember the winner of the most recent real transfer; a grant that is
    // not taken (output stalled) must not rotate priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= SRC_RESET;
        end else if (advance) begin
            last_grant_r <= grant_to_src(grant_s);
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

`endif

    assign grant = grant_s;

endmodule

// File: rtl/custom_logic_merge.sv
// custom_logic_merge: 2:1 stream merge sitting behind the fork stage.
// Takes branch streams A and B, arbitrates between them (rr_arbiter2) and
// emits a single registered valid/ready stream tagged with the source branch.
// Per-branch accepted-beat counters (wrapping) are exposed for debug.
// Optional build macro: CUSTOM_LOGIC_MERGE_PRIORITY_A_EN selects fixed
// priority to A instead of round-robin; ports, latency and counters are the
// same in both builds.
module custom_logic_merge
    import custom_logic_merge_pkg::*;
#(
    parameter int D_WIDTH   = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [D_WIDTH-1:0]   up_data_a,
    input  logic                 up_valid_a,
    output logic                 up_ready_a,
    input  logic [D_WIDTH-1:0]   up_data_b,
    input  logic                 up_valid_b,
    output logic                 up_ready_b,
    output logic [D_WIDTH-1:0]   down_data,
    output logic                 down_src,
    output logic                 down_valid,
    input  logic                 down_ready,
    output logic [CNT_WIDTH-1:0] cnt_a,
    output logic [CNT_WIDTH-1:0] cnt_b
);

    // Output slot and debug counters.
    logic [D_WIDTH-1:0]   down_data_r;
    src_t                 down_src_r;
    logic                 down_valid_r;
    logic [CNT_WIDTH-1:0] cnt_a_r;
    logic [CNT_WIDTH-1:0] cnt_b_r;

    // Handshake decode.
    logic                 load_s;
    logic [GRANT_W-1:0]   req_s;
    logic [GRANT_W-1:0]   grant_s;
    logic                 up_ready_a_s;
    logic                 up_ready_b_s;
    logic                 xfer_a_s;
    logic                 xfer_b_s;
    logic                 advance_s;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [D_WIDTH-1:0]   DATA_ZERO = {D_WIDTH{1'b0}};

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_s),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Handshake decode: the slot can take a new beat when it is empty or is
    // being drained this cycle; only the granted branch sees ready.
    always_comb begin
        load_s       = (~down_valid_r) | down_ready;
        req_s        = {up_valid_b, up_valid_a};
        up_ready_a_s = load_s & grant_s[0];
        up_ready_b_s = load_s & grant_s[1];
        xfer_a_s     = up_valid_a & up_ready_a_s;
        xfer_b_s     = up_valid_b & up_ready_b_s;
        advance_s    = xfer_a_s | xfer_b_s;
    end

    // Output slot: capture the transferred beat, empty the slot when loading
    // with nothing granted, and hold everything stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            down_valid_r <= 1'b0;
            down_data_r  <= DATA_ZERO;
            down_src_r   <= SRC_A;
        end else if (load_s) begin
            if (xfer_a_s) begin
                down_valid_r <= 1'b1;
                down_data_r  <= up_data_a;
                down_src_r   <= SRC_A;
            end else if (xfer_b_s) begin
                down_valid_r <= 1'b1;
                down_data_r  <= up_data_b;
                down_src_r   <= SRC_B;
            end else begin
                down_valid_r <= 1'b0;
                down_data_r  <= down_data_r;
                down_src_r   <= down_src_r;
            end
        end else begin
            down_valid_r <= down_valid_r;
            down_data_r  <= down_data_r;
            down_src_r   <= down_src_r;
        end
    end

    // Per-branch accepted-beat counters; they wrap naturally at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_r <= CNT_ZERO;
            cnt_b_r <= CNT_ZERO;
        end else if (xfer_a_s) begin
            cnt_a_r <= cnt_a_r + CNT_ONE;
            cnt_b_r <= cnt_b_r;
        end else if (xfer_b_s) begin
            cnt_a_r <= cnt_a_r;
            cnt_b_r <= cnt_b_r + CNT_ONE;
        end else begin
            cnt_a_r <= cnt_a_r;
            cnt_b_r <= cnt_b_r;
        end
    end

    assign up_ready_a = up_ready_a_s;
    assign up_ready_b = up_ready_b_s;
    assign down_data  = down_data_r;
    assign down_src   = down_src_r;
    assign down_valid = down_valid_r;
    assign cnt_a      = cnt_a_r;
    assign cnt_b      = cnt_b_r;

endmodule

// File: tb/tb_custom_logic_merge.sv
// tb_custom_logic_merge: self-checking bench for custom_logic_merge.
// Directed scenarios with fixed expectations plus a randomized run checked
// against a behavioural model of the merge rules.
`timescale 1ns/1ps
module tb_custom_logic_merge;

    localparam int D_WIDTH   = 6;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [D_WIDTH-1:0]   up_data_a = 6'h00;
    logic                 up_valid_a = 1'b0;
    logic                 up_ready_a;
    logic [D_WIDTH-1:0]   up_data_b = 6'h00;
    logic                 up_valid_b = 1'b0;
    logic                 up_ready_b;
    logic [D_WIDTH-1:0]   down_data;
    logic                 down_src;
    logic                 down_valid;
    logic                 down_ready = 1'b0;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;

    int errors = 0;
    int checks = 0;

    custom_logic_merge #(.D_WIDTH(D_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst),
        .up_data_a(up_data_a), .up_valid_a(up_valid_a), .up_ready_a(up_ready_a),
        .up_data_b(up_data_b), .up_valid_b(up_valid_b), .up_ready_b(up_ready_b),
        .down_data(down_data), .down_src(down_src), .down_valid(down_valid),
        .down_ready(down_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic         m_valid = 1'b0;
    logic [5:0]   m_data  = 6'h00;
    logic         m_src   = 1'b0;
    logic         m_last  = 1'b1;   // 1 = B won last
    int           m_ca    = 0;
    int           m_cb    = 0;
    logic [1:0]   m_g;
    logic         m_load;

    // Which branch the rules select given the requesters and the last winner.
    function automatic logic [1:0] pick(input logic va, input logic vb, input logic last);
`ifdef CUSTOM_LOGIC_MERGE_PRIORITY_A_EN
        if (va) return 2'b01;
        if (vb) return 2'b10;
        return 2'b00;
`else
        if (va && vb) return last ? 2'b01 : 2'b10;
        return {vb, va};
`endif
    endfunction

    assign m_g    = pick(up_valid_a, up_valid_b, m_last);
    assign m_load = !m_valid || down_ready;

    // Model state advance, once per rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0; m_last <= 1'b1; m_ca <= 0; m_cb <= 0;
        end else if (m_load && m_g[0]) begin
            m_valid <= 1'b1; m_data <= up_data_a; m_src <= 1'b0; m_last <= 1'b0; m_ca <= m_ca + 1;
        end else if (m_load && m_g[1]) begin
            m_valid <= 1'b1; m_data <= up_data_b; m_src <= 1'b1; m_last <= 1'b1; m_cb <= m_cb + 1;
        end else if (m_load) begin
            m_valid <= 1'b0;
        end
    end

    // Apply one cycle of inputs at the falling edge and let them settle.
    task automatic drive(input logic va, input logic [5:0] da, input logic vb,
                         input logic [5:0] db, input logic dr);
        @(negedge clk);
        up_valid_a = va; up_data_a = da; up_valid_b = vb; up_data_b = db; down_ready = dr;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", down_valid); end
        checks++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt_a got=%0d exp=0", cnt_a); end
        checks++; if (cnt_b !== 8'd0) begin errors++; $display("FAIL reset_cnt_b got=%0d exp=0", cnt_b); end
        checks++; if (up_ready_a !== 1'b0 || up_ready_b !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b%b exp=00", up_ready_a, up_ready_b); end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%b exp=0", down_valid); end
    endtask

    task automatic test_fairness();
        int na = 0;
        int nb = 0;
        logic [5:0] exp_d;
        logic       exp_s;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1'b1, 6'h01 + 6'(na), 1'b1, 6'h21 + 6'(nb), 1'b1);
            else       drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
            checks++; if (up_ready_a && up_ready_b) begin errors++; $display("FAIL fair_both_ready got=11 exp=one-hot"); end
            if (up_ready_a) na++;
            if (up_ready_b) nb++;
            if (i > 0) begin
                exp_s = 1'((i - 1) % 2);
                exp_d = exp_s ? 6'h21 + 6'((i - 1) / 2) : 6'h01 + 6'((i - 1) / 2);
                checks++;
                if (down_valid !== 1'b1 || down_data !== exp_d || down_src !== exp_s) begin
                    errors++;
                    $display("FAIL fair_beat%0d got=%b/%h/%b exp=1/%h/%b", i - 1, down_valid, down_data, down_src, exp_d, exp_s);
                end
            end
        end
        checks++; if (cnt_a !== 8'd4 || cnt_b !== 8'd4) begin errors++; $display("FAIL fair_counts got=%0d/%0d exp=4/4", cnt_a, cnt_b); end
    endtask

    task automatic test_backpressure();
        drive(1'b0, 6'h00, 1'b1, 6'h15, 1'b1);
        checks++; if (up_ready_b !== 1'b1) begin errors++; $display("FAIL bp_load_b got=%b exp=1", up_ready_b); end
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'h0A, 1'b1, 6'h16, 1'b0);
            checks++;
            if (down_valid !== 1'b1 || down_data !== 6'h15 || down_src !== 1'b1) begin
                errors++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/15/1", k, down_valid, down_data, down_src);
            end
            checks++; if (up_ready_a !== 1'b0 || up_ready_b !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got=%b%b exp=00", k, up_ready_a, up_ready_b); end
        end
        drive(1'b1, 6'h0A, 1'b1, 6'h16, 1'b1);
        checks++; if (up_ready_a !== 1'b1 || up_ready_b !== 1'b0) begin errors++; $display("FAIL bp_release got=%b%b exp=a1b0", up_ready_a, up_ready_b); end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
        checks++;
        if (down_valid !== 1'b1 || down_data !== 6'h0A || down_src !== 1'b0) begin
            errors++; $display("FAIL bp_no_bubble got=%b/%h/%b exp=1/0a/0", down_valid, down_data, down_src);
        end
    endtask

`ifndef CUSTOM_LOGIC_MERGE_PRIORITY_A_EN
    task automatic test_single_source();
        logic [5:0] exp_d;
        logic       exp_s;
        for (int i = 0; i <= 7; i++) begin
            if (i < 5)       drive(1'b0, 6'h00, 1'b1, 6'h30 + 6'(i), 1'b1);
            else if (i == 5) drive(1'b1, 6'h3A, 1'b1, 6'h35, 1'b1);
            else if (i == 6) drive(1'b1, 6'h3B, 1'b1, 6'h35, 1'b1);
            else             drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
            if (i == 5) begin
                checks++; if (up_ready_a !== 1'b1 || up_ready_b !== 1'b0) begin errors++; $display("FAIL single_turn_a got=%b%b exp=a1b0", up_ready_a, up_ready_b); end
            end
            if (i == 6) begin
                checks++; if (up_ready_a !== 1'b0 || up_ready_b !== 1'b1) begin errors++; $display("FAIL single_turn_b got=%b%b exp=a0b1", up_ready_a, up_ready_b); end
            end
            if (i > 0) begin
                if (i - 1 < 5)       begin exp_d = 6'h30 + 6'(i - 1); exp_s = 1'b1; end
                else if (i - 1 == 5) begin exp_d = 6'h3A; exp_s = 1'b0; end
                else                 begin exp_d = 6'h35; exp_s = 1'b1; end
                checks++;
                if (down_valid !== 1'b1 || down_data !== exp_d || down_src !== exp_s) begin
                    errors++; $display("FAIL single_beat%0d got=%b/%h/%b exp=1/%h/%b", i - 1, down_valid, down_data, down_src, exp_d, exp_s);
                end
            end
        end
    endtask
`else
    task automatic test_priority();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 6'(i), 1'b1, 6'h20 + 6'(i), 1'b1);
            checks++; if (up_ready_a !== 1'b1 || up_ready_b !== 1'b0) begin errors++; $display("FAIL prio_grant%0d got=%b%b exp=a1b0", i, up_ready_a, up_ready_b); end
        end
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    endtask
`endif

    task automatic test_counter_wrap();
        logic [5:0] prev = 6'h00;
        logic [5:0] d;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            d = 6'($urandom);
            if (i < 256) drive(1'b1, d, 1'b0, 6'h00, 1'b1);
            else         drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
            if (i > 0) begin
                checks++; if (down_valid !== 1'b1 || down_data !== prev) begin errors++; $display("FAIL wrap_beat%0d got=%b/%h exp=1/%h", i - 1, down_valid, down_data, prev); end
            end
            if (i == 255) begin
                checks++; if (cnt_a !== 8'd255) begin errors++; $display("FAIL wrap_cnt_full got=%0d exp=255", cnt_a); end
            end
            prev = d;
        end
        checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin errors++; $display("FAIL wrap_cnt_zero got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 6'h11, 1'b0, 6'h00, 1'b1);
        drive(1'b1, 6'h12, 1'b1, 6'h13, 1'b0);
        checks++; if (down_valid !== 1'b1 || down_data !== 6'h11) begin errors++; $display("FAIL mid_stalled got=%b/%h exp=1/11", down_valid, down_data); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; down_ready = 1'b1;
        #1;
        checks++; if (down_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", down_valid); end
        checks++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0) begin errors++; $display("FAIL mid_counts got=%0d/%0d exp=0/0", cnt_a, cnt_b); end
        checks++; if (up_ready_a !== 1'b1 || up_ready_b !== 1'b0) begin errors++; $display("FAIL mid_first_a got=%b%b exp=a1b0", up_ready_a, up_ready_b); end
        drive(1'b1, 6'h14, 1'b1, 6'h13, 1'b1);
        checks++; if (down_valid !== 1'b1 || down_data !== 6'h12 || down_src !== 1'b0) begin errors++; $display("FAIL mid_beat got=%b/%h/%b exp=1/12/0", down_valid, down_data, down_src); end
`ifndef CUSTOM_LOGIC_MERGE_PRIORITY_A_EN
        checks++; if (up_ready_b !== 1'b1) begin errors++; $display("FAIL mid_then_b got=%b exp=1", up_ready_b); end
`else
        checks++; if (up_ready_a !== 1'b1) begin errors++; $display("FAIL mid_then_a got=%b exp=1", up_ready_a); end
`endif
        drive(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom), 6'($urandom), 1'($urandom), 6'($urandom), ($urandom_range(3, 0) != 0));
            checks++; if (up_ready_a !== (m_load && m_g[0])) begin errors++; $display("FAIL rnd_ready_a@%0d got=%b exp=%b", i, up_ready_a, m_load && m_g[0]); end
            checks++; if (up_ready_b !== (m_load && m_g[1])) begin errors++; $display("FAIL rnd_ready_b@%0d got=%b exp=%b", i, up_ready_b, m_load && m_g[1]); end
            checks++; if (down_valid !== m_valid) begin errors++; $display("FAIL rnd_valid@%0d got=%b exp=%b", i, down_valid, m_valid); end
            if (m_valid) begin
                checks++; if (down_data !== m_data || down_src !== m_src) begin errors++; $display("FAIL rnd_beat@%0d got=%h/%b exp=%h/%b", i, down_data, down_src, m_data, m_src); end
            end
            checks++; if (cnt_a !== 8'(m_ca % 256) || cnt_b !== 8'(m_cb % 256)) begin errors++; $display("FAIL rnd_counts@%0d got=%0d/%0d exp=%0d/%0d", i, cnt_a, cnt_b, m_ca % 256, m_cb % 256); end
        end
    endtask

    initial begin
        test_reset();
        test_fairness();
        test_backpressure();
`ifndef CUSTOM_LOGIC_MERGE_PRIORITY_A_EN
        test_single_source();
`else
        test_priority();
`endif
        test_counter_wrap();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
